keccak_absorb_ctrl: RTL and testbench

Sequencing controller for the SHAKE128 absorb path (rate 1344 bits = 21 × 64-bit lanes). It accepts a word-granular message stream with a valid/ready handshake and feeds the 1344-bit serial-in/parallel-out rate register one lane per load. It generates the SHAKE pad words after the last message word, then hands each completed block to the permutation core with a start/done handshake. It flags completion of absorption once the final padded block has been permuted.

---
 rtl/keccak_absorb_ctrl.sv | 172 +++++++++++++++++
 tb/tb_keccak_absorb_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_absorb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_absorb_ctrl
//  Description : SHAKE128 absorb sequencer. Streams message lanes into the
//                1344-bit rate register, appends the SHAKE pad lanes, and
//                hands each full block to the permutation core through a
//                start/done handshake. Flags absorb_done after the final
//                padded block has been permuted.
//  Revision    : 1.0  initial release
// ============================================================================
module keccak_absorb_ctrl #(
    parameter int          DATA_SIZE = 64,
    parameter int          WORDS     = 21,
    parameter logic [7:0]  PAD_BYTE  = 8'h1F
) (
    input  logic                  clk,
    input  logic                  hash_init,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_SIZE-1:0]  in_data,
    input  logic                  in_last,
    output logic [DATA_SIZE-1:0]  sipo_data,
    output logic                  load_en,
    output logic                  cntr_zero,
    input  logic                  is_loaded,
    output logic                  perm_start,
    input  logic                  perm_done,
    output logic                  absorb_done
);

    // Lane counter width and the index of the last lane in a block.
    localparam int                 c_CNT_W = $clog2(WORDS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WORDS - 1);

    // Controller states, explicitly encoded.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_PAD         = 3'd2,
        S_WAIT_LOADED = 3'd3,
        S_PERM        = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_word_cnt;
    logic                  r_last_seen;    // final message word has been taken
    logic                  r_pad_started;  // first pad lane already emitted
    logic                  r_perm_start;
    logic                  r_absorb_done;

    logic [c_CNT_W-1:0]    w_cnt_next;
    logic                  w_cnt_last;
    logic [DATA_SIZE-1:0]  w_pad_lane;

    // Lane index bookkeeping: counter wraps from the last lane back to 0.
    assign w_cnt_last = (r_word_cnt == c_LAST);
    assign w_cnt_next = w_cnt_last ? '0 : r_word_cnt + c_CNT_W'(1);

    // Pad lane: domain byte on the first pad lane, top bit on the last lane
    // of the block; both can land on the same lane.
    always_comb begin
        w_pad_lane = '0;
        if (!r_pad_started) begin
            w_pad_lane[7:0] = PAD_BYTE;
        end
        if (w_cnt_last) begin
            w_pad_lane[DATA_SIZE-1] = 1'b1;
        end
    end

    // Datapath handshake outputs are combinational so a word can be taken
    // every cycle without an input buffer.
    always_comb begin
        in_ready  = 1'b0;
        load_en   = 1'b0;
        sipo_data = '0;
        case (r_state)
            S_LOAD: begin
                in_ready  = 1'b1;
                load_en   = in_valid;
                sipo_data = in_valid ? in_data : '0;
            end
            S_PAD: begin
                load_en   = 1'b1;
                sipo_data = w_pad_lane;
            end
            default: begin
                in_ready  = 1'b0;
                load_en   = 1'b0;
                sipo_data = '0;
            end
        endcase
        cntr_zero = load_en && w_cnt_last;
    end

    assign perm_start  = r_perm_start;
    assign absorb_done = r_absorb_done;

    // Block sequencing FSM with registered perm_start and absorb_done.
    always_ff @(posedge clk or posedge hash_init) begin
        if (hash_init) begin
            r_state       <= S_IDLE;
            r_word_cnt    <= '0;
            r_last_seen   <= 1'b0;
            r_pad_started <= 1'b0;
            r_perm_start  <= 1'b0;
            r_absorb_done <= 1'b0;
        end else begin
            r_perm_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    if (in_valid) begin
                        r_word_cnt <= w_cnt_next;
                        if (in_last) begin
                            r_last_seen <= 1'b1;
                            // A last word that fills the block forces an
                            // extra, pad-only block after this permutation.
                            r_state     <= w_cnt_last ? S_WAIT_LOADED : S_PAD;
                        end else if (w_cnt_last) begin
                            r_state <= S_WAIT_LOADED;
                        end
                    end
                end

                S_PAD: begin
                    r_word_cnt    <= w_cnt_next;
                    r_pad_started <= 1'b1;
                    if (w_cnt_last) begin
                        r_state <= S_WAIT_LOADED;
                    end
                end

                S_WAIT_LOADED: begin
                    if (is_loaded) begin
                        r_state      <= S_PERM;
                        r_perm_start <= 1'b1;
                    end
                end

                S_PERM: begin
                    if (perm_done) begin
                        // Padding always runs to the end of its block before
                        // the permutation, so a started pad means finished.
                        if (r_pad_started) begin
                            r_state       <= S_DONE;
                            r_absorb_done <= 1'b1;
                        end else if (r_last_seen) begin
                            r_state <= S_PAD;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_absorb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_absorb_ctrl
//  Description : Directed self-checking bench for keccak_absorb_ctrl with a
//                behavioural rate register and permutation responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keccak_absorb_ctrl;

    localparam int NW = 21;

    logic        clk = 1'b0;
    logic        hash_init;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [63:0] sipo_data;
    logic        load_en;
    logic        cntr_zero;
    logic        is_loaded;
    logic        perm_start;
    logic        perm_done;
    logic        absorb_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] msg [0:63];

    // Monitor logs (written only by the monitor)
    logic [63:0] lanes_q[$];
    bit          cz_q[$];
    int          lcyc_q[$];
    int          ps_lanes_q[$];
    int          ps_cyc_q[$];
    int          cyc  = 0;
    int          viol = 0;

    // Responder controls
    int lat_a = 0;
    int lat_b = 0;
    int stray_cnt = 0;
    int stray_ack = 0;
    int ps_seen = 0;
    bit resp_active = 1'b0;
    int resp_cnt = 0;

    logic pend;

    keccak_absorb_ctrl #(
        .DATA_SIZE (64),
        .WORDS     (21),
        .PAD_BYTE  (8'h1F)
    ) dut (
        .clk         (clk),
        .hash_init   (hash_init),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .sipo_data   (sipo_data),
        .load_en     (load_en),
        .cntr_zero   (cntr_zero),
        .is_loaded   (is_loaded),
        .perm_start  (perm_start),
        .perm_done   (perm_done),
        .absorb_done (absorb_done)
    );

    always #5 clk = ~clk;

    // Rate register model: full-block flag one edge after the lane-20 load,
    // cleared by the next block's first lane.
    always @(posedge clk or posedge hash_init) begin
        if (hash_init) begin
            pend      <= 1'b0;
            is_loaded <= 1'b0;
        end else begin
            pend <= load_en && cntr_zero;
            if (pend)         is_loaded <= 1'b1;
            else if (load_en) is_loaded <= 1'b0;
        end
    end

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (load_en === 1'b1) begin
            lanes_q.push_back(sipo_data);
            cz_q.push_back(cntr_zero);
            lcyc_q.push_back(cyc);
        end
        if (perm_start === 1'b1) begin
            ps_lanes_q.push_back(lanes_q.size());
            ps_cyc_q.push_back(cyc);
        end
        if (in_ready === 1'b1 && (perm_start === 1'b1 || absorb_done === 1'b1)) viol = viol + 1;
        if (in_ready === 1'b1 && load_en !== in_valid) viol = viol + 1;
        if (absorb_done === 1'b1 && load_en === 1'b1) viol = viol + 1;
    end

    // Permutation core model: perm_done after an alternating latency, plus
    // on-demand stray pulses.
    initial begin
        perm_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            perm_done = 1'b0;
            if (hash_init === 1'b1) begin
                resp_active = 1'b0;
            end else begin
                if (stray_cnt != stray_ack) begin
                    stray_ack = stray_cnt;
                    perm_done = 1'b1;
                end
                if (perm_start === 1'b1 && !resp_active) begin
                    resp_active = 1'b1;
                    resp_cnt    = (ps_seen % 2 == 0) ? lat_a : lat_b;
                    ps_seen     = ps_seen + 1;
                end
                if (resp_active) begin
                    if (resp_cnt == 0) begin
                        perm_done   = 1'b1;
                        resp_active = 1'b0;
                    end else begin
                        resp_cnt = resp_cnt - 1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Expected lane j of the padded stream for an n-word message.
    function automatic logic [63:0] exp_lane(input int n, input int j);
        int          total;
        logic [63:0] v;
        total = ((n + NW) / NW) * NW;
        v = (j < n) ? msg[j] : 64'h0;
        if (j == n)         v = v | 64'h0000_0000_0000_001F;
        if (j == total - 1) v = v | 64'h8000_0000_0000_0000;
        return v;
    endfunction

    function automatic logic [63:0] got_lane(input int idx);
        return (idx < lanes_q.size()) ? lanes_q[idx] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic logic got_cz(input int idx);
        return (idx < cz_q.size()) ? cz_q[idx] : 1'bx;
    endfunction

    task automatic fill_msg(input logic [63:0] seed);
        for (int i = 0; i < 64; i++) begin
            msg[i] = seed ^ (64'(i) << 16) ^ 64'(i * 3 + 1);
        end
    endtask

    task automatic do_reset();
        hash_init = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        hash_init = 1'b0;
    endtask

    // Offers n words starting at msg[0]; aligned to posedge+1 on entry/exit.
    task automatic send_words(input int n, input bit gaps, input bit mark_last, output bit ok);
        int i = 0;
        int c = 0;
        bit acc;
        while (i < n && c < 4000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = ~msg[i];
            end else begin
                in_valid = 1'b1;
                in_data  = msg[i];
                in_last  = mark_last && (i == n - 1);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            c++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_absorb(output bit ok);
        int c = 0;
        while (absorb_done !== 1'b1 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        ok = (absorb_done === 1'b1);
    endtask

    task automatic absorb_msg(input int n, input bit gaps, output bit ok);
        bit s_ok;
        bit d_ok;
        send_words(n, gaps, 1'b1, s_ok);
        wait_absorb(d_ok);
        repeat (2) @(posedge clk);
        #1;
        ok = s_ok && d_ok;
    endtask

    task automatic test_reset();
        hash_init = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 64'hFFFF_0000_FFFF_0000;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b0)   begin miscompares++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        vectors++; if (load_en !== 1'b0)    begin miscompares++; $display("FAIL reset load_en: got %b want 0", load_en); end
        vectors++; if (cntr_zero !== 1'b0)  begin miscompares++; $display("FAIL reset cntr_zero: got %b want 0", cntr_zero); end
        vectors++; if (sipo_data !== 64'h0) begin miscompares++; $display("FAIL reset sipo_data: got %h want 0", sipo_data); end
        vectors++; if (perm_start !== 1'b0) begin miscompares++; $display("FAIL reset perm_start: got %b want 0", perm_start); end
        vectors++; if (absorb_done !== 1'b0) begin miscompares++; $display("FAIL reset absorb_done: got %b want 0", absorb_done); end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        hash_init = 1'b0;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset idle in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset load in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_word();
        int lb, pb, vb;
        bit ok;
        lat_a = 3; lat_b = 3;
        do_reset();
        fill_msg(64'h0);
        msg[0] = 64'h0123_4567_89AB_CDEF;
        lb = lanes_q.size(); pb = ps_cyc_q.size(); vb = viol;
        absorb_msg(1, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL one_word completion: got timeout want absorb_done"); end
        vectors++; if (lanes_q.size() - lb != NW) begin miscompares++; $display("FAIL one_word lane_count: got %0d want %0d", lanes_q.size() - lb, NW); end
        for (int j = 0; j < NW; j++) begin
            vectors++;
            if (got_lane(lb + j) !== exp_lane(1, j) || got_cz(lb + j) !== (j == NW - 1)) begin
                miscompares++;
                $display("FAIL one_word lane%0d: got %h cz=%b want %h cz=%b", j, got_lane(lb + j), got_cz(lb + j), exp_lane(1, j), (j == NW - 1));
            end
        end
        vectors++; if (ps_cyc_q.size() - pb != 1) begin miscompares++; $display("FAIL one_word perm_starts: got %0d want 1", ps_cyc_q.size() - pb); end
        vectors++;
        if (ps_cyc_q.size() > pb && lcyc_q.size() >= lb + NW && ps_cyc_q[pb] - lcyc_q[lb + NW - 1] == 3) begin
        end else begin
            miscompares++; $display("FAIL one_word perm_start_latency: got other want 3 cycles after lane 20");
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (absorb_done !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL one_word done_hold: got done=%b ready=%b want 1/0", absorb_done, in_ready); end
        vectors++; if (viol != vb) begin miscompares++; $display("FAIL one_word handshake_rules: got %0d violations want 0", viol - vb); end
    endtask

    task automatic test_twenty_words();
        int lb, pb;
        bit ok;
        lat_a = 0; lat_b = 0;
        do_reset();
        fill_msg(64'h5A00_1100_0000_0000);
        lb = lanes_q.size(); pb = ps_cyc_q.size();
        absorb_msg(20, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL twenty completion: got timeout want absorb_done"); end
        vectors++; if (lanes_q.size() - lb != NW) begin miscompares++; $display("FAIL twenty lane_count: got %0d want %0d", lanes_q.size() - lb, NW); end
        for (int j = 0; j < NW; j++) begin
            vectors++;
            if (got_lane(lb + j) !== exp_lane(20, j) || got_cz(lb + j) !== (j == NW - 1)) begin
                miscompares++;
                $display("FAIL twenty lane%0d: got %h cz=%b want %h", j, got_lane(lb + j), got_cz(lb + j), exp_lane(20, j));
            end
        end
        vectors++; if (got_lane(lb + 20) !== 64'h8000_0000_0000_001F) begin miscompares++; $display("FAIL twenty lane20_pad: got %h want 800000000000001f", got_lane(lb + 20)); end
        vectors++; if (ps_cyc_q.size() - pb != 1) begin miscompares++; $display("FAIL twenty perm_starts: got %0d want 1", ps_cyc_q.size() - pb); end
    endtask

    task automatic test_full_block();
        int lb, pb;
        bit ok;
        lat_a = 2; lat_b = 2;
        do_reset();
        fill_msg(64'h3C3C_0000_7700_0000);
        lb = lanes_q.size(); pb = ps_cyc_q.size();
        absorb_msg(21, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL full_block completion: got timeout want absorb_done"); end
        vectors++; if (lanes_q.size() - lb != 2 * NW) begin miscompares++; $display("FAIL full_block lane_count: got %0d want %0d", lanes_q.size() - lb, 2 * NW); end
        for (int j = 0; j < 2 * NW; j++) begin
            vectors++;
            if (got_lane(lb + j) !== exp_lane(21, j) || got_cz(lb + j) !== (j % NW == NW - 1)) begin
                miscompares++;
                $display("FAIL full_block lane%0d: got %h cz=%b want %h", j, got_lane(lb + j), got_cz(lb + j), exp_lane(21, j));
            end
        end
        vectors++; if (ps_cyc_q.size() - pb != 2) begin miscompares++; $display("FAIL full_block perm_starts: got %0d want 2", ps_cyc_q.size() - pb); end
        vectors++;
        if (ps_cyc_q.size() - pb == 2 && ps_lanes_q[pb] - lb == NW && ps_lanes_q[pb + 1] - lb == 2 * NW) begin
        end else begin
            miscompares++; $display("FAIL full_block perm_start_order: got starts not at block boundaries want after lanes 21 and 42");
        end
    endtask

    task automatic test_back_to_back();
        int lb, pb, vb;
        bit ok;
        lat_a = 0; lat_b = 24;
        do_reset();
        fill_msg(64'hA5A5_0000_0000_9000);
        lb = lanes_q.size(); pb = ps_cyc_q.size(); vb = viol;
        absorb_msg(45, 1'b1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b completion: got timeout want absorb_done"); end
        vectors++; if (lanes_q.size() - lb != 3 * NW) begin miscompares++; $display("FAIL b2b lane_count: got %0d want %0d", lanes_q.size() - lb, 3 * NW); end
        for (int j = 0; j < 3 * NW; j++) begin
            vectors++;
            if (got_lane(lb + j) !== exp_lane(45, j) || got_cz(lb + j) !== (j % NW == NW - 1)) begin
                miscompares++;
                $display("FAIL b2b lane%0d: got %h cz=%b want %h", j, got_lane(lb + j), got_cz(lb + j), exp_lane(45, j));
            end
        end
        vectors++; if (ps_cyc_q.size() - pb != 3) begin miscompares++; $display("FAIL b2b perm_starts: got %0d want 3", ps_cyc_q.size() - pb); end
        for (int b = 0; b < 3; b++) begin
            vectors++;
            if (pb + b >= ps_lanes_q.size() || ps_lanes_q[pb + b] - lb != (b + 1) * NW) begin
                miscompares++; $display("FAIL b2b block%0d_boundary: got start not after lane %0d want after lane %0d", b, (b + 1) * NW, (b + 1) * NW);
            end
        end
        vectors++; if (viol != vb) begin miscompares++; $display("FAIL b2b handshake_rules: got %0d violations want 0", viol - vb); end
    endtask

    task automatic test_hash_init_mid_block();
        int lb, pb;
        bit ok;
        lat_a = 0; lat_b = 0;
        do_reset();
        fill_msg(64'h7E00_0000_0000_0000);
        lb = lanes_q.size();
        send_words(7, 1'b0, 1'b0, ok);
        vectors++; if (!ok || lanes_q.size() - lb != 7) begin miscompares++; $display("FAIL mid_block prefix: got %0d lanes want 7", lanes_q.size() - lb); end
        in_valid  = 1'b1;
        in_data   = msg[7];
        hash_init = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || load_en !== 1'b0 || cntr_zero !== 1'b0 || sipo_data !== 64'h0 || perm_start !== 1'b0 || absorb_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_block reset_outputs: got ready=%b load=%b cz=%b data=%h ps=%b done=%b want all 0", in_ready, load_en, cntr_zero, sipo_data, perm_start, absorb_done);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        hash_init = 1'b0;
        fill_msg(64'h0);
        msg[0] = 64'hFEED_FACE_0BAD_F00D;
        lb = lanes_q.size(); pb = ps_cyc_q.size();
        absorb_msg(1, 1'b0, ok);
        vectors++; if (!ok || lanes_q.size() - lb != NW) begin miscompares++; $display("FAIL mid_block restart: got %0d lanes want %0d", lanes_q.size() - lb, NW); end
        for (int j = 0; j < NW; j++) begin
            vectors++;
            if (got_lane(lb + j) !== exp_lane(1, j)) begin
                miscompares++; $display("FAIL mid_block restart lane%0d: got %h want %h", j, got_lane(lb + j), exp_lane(1, j));
            end
        end
        vectors++; if (ps_cyc_q.size() - pb != 1) begin miscompares++; $display("FAIL mid_block perm_starts: got %0d want 1", ps_cyc_q.size() - pb); end
    endtask

    task automatic test_hash_init_mid_perm();
        int lb, pb, c;
        bit ok;
        lat_a = 24; lat_b = 24;
        do_reset();
        fill_msg(64'h0);
        msg[0] = 64'h1111_2222_3333_4444;
        pb = ps_cyc_q.size();
        send_words(1, 1'b0, 1'b1, ok);
        c = 0;
        while (ps_cyc_q.size() == pb && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        vectors++; if (ps_cyc_q.size() == pb) begin miscompares++; $display("FAIL mid_perm reach_perm: got no perm_start want one"); end
        repeat (5) @(posedge clk);
        #1;
        hash_init = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || load_en !== 1'b0 || cntr_zero !== 1'b0 || sipo_data !== 64'h0 || perm_start !== 1'b0 || absorb_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_perm reset_outputs: got ready=%b load=%b cz=%b data=%h ps=%b done=%b want all 0", in_ready, load_en, cntr_zero, sipo_data, perm_start, absorb_done);
        end
        @(posedge clk);
        #1;
        hash_init = 1'b0;
        lat_a = 0; lat_b = 0;
        repeat (2) @(posedge clk);
        #1;
        lb = lanes_q.size(); pb = ps_cyc_q.size();
        stray_cnt = stray_cnt + 1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (absorb_done !== 1'b0 || in_ready !== 1'b1 || lanes_q.size() != lb || ps_cyc_q.size() != pb) begin
            miscompares++;
            $display("FAIL mid_perm stray_done: got done=%b ready=%b lanes=%0d starts=%0d want 0/1/0/0", absorb_done, in_ready, lanes_q.size() - lb, ps_cyc_q.size() - pb);
        end
        msg[0] = 64'h0BAD_CAFE_1234_5678;
        absorb_msg(1, 1'b0, ok);
        vectors++; if (!ok || lanes_q.size() - lb != NW) begin miscompares++; $display("FAIL mid_perm restart: got %0d lanes want %0d", lanes_q.size() - lb, NW); end
        for (int j = 0; j < NW; j++) begin
            vectors++;
            if (got_lane(lb + j) !== exp_lane(1, j)) begin
                miscompares++; $display("FAIL mid_perm restart lane%0d: got %h want %h", j, got_lane(lb + j), exp_lane(1, j));
            end
        end
        vectors++; if (ps_cyc_q.size() - pb != 1) begin miscompares++; $display("FAIL mid_perm perm_starts: got %0d want 1", ps_cyc_q.size() - pb); end
    endtask

    initial begin
        hash_init = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        test_reset();
        test_one_word();
        test_twenty_words();
        test_full_block();
        test_back_to_back();
        test_hash_init_mid_block();
        test_hash_init_mid_perm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
